mdc_delay_commutator: RTL
=========================

Name: mdc_delay_commutator

Overview:
- Reordering stage of the 32-point pipelined IFFT, placed directly in front of each commutator switch in the dual-path (MDC) datapath.
- Delays the lower input path by DELAY samples, then swaps or bypasses the two paths with a self-generated phase signal.
- Delays the resulting upper path by another DELAY samples.
- Output pairs are spaced DELAY samples apart, as required by the next radix-2 butterfly.
- Stream-controlled: data advances only on accepted samples.

Parameters:
- DELAY, 2, samples per delay line and half-period of the swap phase; power of two, 1..16.
- W, 14, component width; S4.9 two's complement.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample pair on UI/LI is accepted this cycle.
- in_start  input  1  with in_valid: this pair is sample k=0 of a new frame.
- UI_real, UI_imag  input  W each  upper path input, S4.9.
- LI_real, LI_imag  input  W each  lower path input, S4.9.
- out_valid  output  1  UO/LO hold a valid pair.
- UO_real, UO_imag  output  W each  upper path output, S4.9.
- LO_real, LO_imag  output  W each  lower path output, S4.9.
- phase  output  1  internal swap control; 1 = bypass, 0 = switch (commutator encoding).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs and both delay lines cleared to 0; out_valid=0.
  - Sample index counter k=0; fill counter=0; phase=1.
- Accepted sample index k counts in_valid cycles within a frame.
  - in_start with in_valid forces the current sample to k=0 and clears the fill counter. Delay contents are kept but treated as stale.
- phase = NOT bit log2(DELAY) of k: bypass for k mod 2·DELAY < DELAY, switch otherwise.
  - The phase for a given sample is applied in the same cycle it is accepted.
  - phase output is registered and shows the phase of the last accepted sample.
- Datapath per accepted sample k (a = upper input, b = lower input):
  - Lower delay line: bd_k = b_{k-DELAY}.
  - Bypass: u_k = a_k, l_k = bd_k. Switch: u_k = bd_k, l_k = a_k.
  - Upper delay line: UO ← u_{k-DELAY}. LO ← l_k.
- All delay lines shift only when in_valid=1. When in_valid=0, outputs hold and out_valid=0.
- Latency: outputs are registered and appear one clk after accepting sample k.
- out_valid = 1 one cycle after an accepted sample with fill count ≥ DELAY, i.e. the first valid pair is produced at k=DELAY.
- Fill counter saturates at DELAY. The k counter wraps modulo 2·DELAY and is unbounded across frames. Steady state outputs every accepted cycle.
- Resulting order for DELAY=2, per block of 4: (a0,a2), (a1,a3), (b0,b2), (b1,b3).
- Pure data movement, no arithmetic: widths pass through unchanged, no saturation or rounding.
- Simultaneous in_start and in_valid: that sample is both k=0 and stored. in_start without in_valid is ignored.
- Reset mid-frame: immediate clear. The first accepted sample after release is k=0 regardless of in_start.

Test Plan:
- Reset: hold rst_n=0 with random inputs, release → all outputs 0, out_valid=0, phase=1.
- DELAY=2, continuous in_valid, UI_real=0..7 (a), LI_real=100..107 (b), imag=-real:
  - out_valid first high 3 cycles after the first accept.
  - Sequence (0,2), (1,3), (100,102), (101,103), (4,6), (5,7), …
  - Imag parts are mirrored.
- Same stimulus with in_valid deasserted on alternate cycles → identical output order; out_valid only on cycles after accepts; outputs hold in gaps.
- in_start asserted on sample 5 of a running stream → phase restarts bypass; out_valid low for the next 2 accepts; new frame order starts from that sample.
- Extreme values: UI_real=14'h1FFF, LI_real=14'h2000 → values reappear bit-exact, with no sign corruption.
- rst_n pulsed low mid-stream (asynchronous, between edges) → outputs clear immediately; restart yields the same order as the continuous-stream test.

Source files
------------

// File: rtl/mdc_delay_commutator.sv
// mdc_delay_commutator
// Reordering stage in front of each commutator switch of the dual-path
// pipelined IFFT. The lower path is delayed by DELAY samples. The two paths
// are then swapped or bypassed by a self-generated phase. The resulting upper
// path is delayed by another DELAY samples, so each output pair holds two
// samples that are DELAY apart. Data moves only on accepted samples.

module mdc_delay_commutator #(
  parameter int DELAY = 2,   // power of two, 1..16
  parameter int W     = 14   // component width, S4.9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_start,
  input  logic [W-1:0] UI_real,
  input  logic [W-1:0] UI_imag,
  input  logic [W-1:0] LI_real,
  input  logic [W-1:0] LI_imag,
  output logic         out_valid,
  output logic [W-1:0] UO_real,
  output logic [W-1:0] UO_imag,
  output logic [W-1:0] LO_real,
  output logic [W-1:0] LO_imag,
  output logic         phase
);

  // Bit of k that selects bypass/switch, and the widths of both counters.
  localparam int KB = $clog2(DELAY);
  localparam int KW = KB + 1;
  localparam int FW = $clog2(DELAY + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DELAY);

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_t;

  cplx_t         lower_line [DELAY];
  cplx_t         upper_line [DELAY];
  cplx_t         uo_q;
  cplx_t         lo_q;
  logic [KW-1:0] k_q;
  logic [FW-1:0] fill_q;
  logic          out_valid_q;
  logic          phase_q;

  cplx_t         a_in;
  cplx_t         b_in;
  cplx_t         b_delayed;
  cplx_t         u_path;
  cplx_t         l_path;
  logic [KW-1:0] k_cur;
  logic [FW-1:0] fill_cur;
  logic          phase_cur;

  // Index, fill level and swap phase of the sample on the inputs this cycle;
  // in_start rebases the frame so this very sample is k=0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    a_in      = '{re: UI_real, im: UI_imag};
    b_in      = '{re: LI_real, im: LI_imag};
    b_delayed = lower_line[DELAY-1];
    k_cur     = k_q;
    fill_cur  = fill_q;
    if (in_start) begin
      k_cur    = '0;
      fill_cur = '0;
    end
    phase_cur = ~k_cur[KB];
    u_path    = b_delayed;
    l_path    = a_in;
    if (phase_cur) begin
      u_path = a_in;
      l_path = b_delayed;
    end
  end

  // Counters, phase and output registers; everything advances only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      fill_q      <= '0;
      phase_q     <= 1'b1;
      out_valid_q <= 1'b0;
      uo_q        <= '0;
      lo_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= 1'b0;
      if (in_valid) begin
        k_q         <= k_cur + 1'b1;
        fill_q      <= (fill_cur == FILL_MAX) ? FILL_MAX : fill_cur + 1'b1;
        phase_q     <= phase_cur;
        out_valid_q <= (fill_cur == FILL_MAX);
        uo_q        <= upper_line[DELAY-1];
        lo_q        <= l_path;
      end
    end
  end

  // Lower and upper delay lines, shifting one place per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay lines are small flop arrays that must read as zero after reset, so they are cleared explicitly.
      for (int i = 0; i < DELAY; i++) begin
        lower_line[i] <= '0;
        upper_line[i] <= '0;
      end
    end else if (in_valid) begin
      lower_line[0] <= b_in;
      upper_line[0] <= u_path;
      for (int i = 1; i < DELAY; i++) begin
        lower_line[i] <= lower_line[i-1];
        upper_line[i] <= upper_line[i-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign UO_real   = uo_q.re;
  assign UO_imag   = uo_q.im;
  assign LO_real   = lo_q.re;
  assign LO_imag   = lo_q.im;

endmodule
